// File: rtl/pulse_decoder.sv
// Pulse-width decoder: synchronises and glitch-filters sgn_in, measures high pulses and low gaps,
// and decodes bits, minute markers and frame alignment.
module pulse_decoder #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned FILT        = 4,
  parameter int unsigned T_MIN       = 50,
  parameter int unsigned T_SPLIT     = 850,
  parameter int unsigned T_MAX       = 1500,
  parameter int unsigned T_GAP       = 2500,
  parameter bit          LONG_IS_ONE = 1'b0
) (
  input  logic       clk_in,
  input  logic       GSR,
  input  logic       sgn_in,
  output logic       bit_out,
  output logic       flag_out,
  output logic       err_out,
  output logic       min_out,
  output logic [5:0] idx_out,
  output logic       sync_out
);

  localparam int unsigned FW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [CNT_W-1:0] TMIN_C   = CNT_W'(T_MIN);
  localparam logic [CNT_W-1:0] TSPLIT_C = CNT_W'(T_SPLIT);
  localparam logic [CNT_W-1:0] TMAX_C   = CNT_W'(T_MAX);
  localparam logic [CNT_W-1:0] TGAP_C   = CNT_W'(T_GAP);
  localparam logic [5:0]       IDX_LAST = 6'd59;

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic             filt_q, filt_d, filt_prev_q;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
  logic             bit_q, bit_d, flag_q, flag_d, err_q, err_d, min_q, min_d;
  logic [5:0]       idx_q, idx_d;
  logic             rise, fall, legal;

  assign rise  = filt_q & ~filt_prev_q;
  assign fall  = ~filt_q & filt_prev_q;
  assign legal = (hcnt_q >= TMIN_C) && (hcnt_q <= TMAX_C);

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    // Count consecutive synchronised samples that disagree with the filtered level.
    if (sync2_q != filt_q) begin
      if (fcnt_q == FW'(FILT - 1)) begin
        filt_d = sync2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    hcnt_d = hcnt_q;
    lcnt_d = lcnt_q;
    if (fall) begin
      hcnt_d = '0;
    end else if (filt_q && (hcnt_q != '1)) begin
      hcnt_d = hcnt_q + 1'b1;
    end
    if (rise) begin
      lcnt_d = '0;
    end else if (!filt_q && (lcnt_q != '1)) begin
      lcnt_d = lcnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    flag_d  = 1'b0;
    err_d   = 1'b0;
    min_d   = 1'b0;
    if (fall) begin
      if (legal && (idx_q != IDX_LAST)) begin
        flag_d = 1'b1;
        bit_d  = (hcnt_q > TSPLIT_C) ? LONG_IS_ONE : ~LONG_IS_ONE;
        idx_d  = idx_q + 6'd1;
      end else begin
        err_d   = 1'b1;
        state_d = HUNT;
      end
    end
    if (rise && (lcnt_q > TGAP_C)) begin
      min_d   = 1'b1;
      idx_d   = '0;
      state_d = LOCK;
    end
  end

  always_ff @(posedge clk_in) begin
    if (GSR) begin
      state_q     <= HUNT;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      fcnt_q      <= '0;
      hcnt_q      <= '0;
      lcnt_q      <= '0;
      bit_q       <= 1'b0;
      flag_q      <= 1'b0;
      err_q       <= 1'b0;
      min_q       <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sgn_in;
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
      hcnt_q      <= hcnt_d;
      lcnt_q      <= lcnt_d;
      bit_q       <= bit_d;
      flag_q      <= flag_d;
      err_q       <= err_d;
      min_q       <= min_d;
      idx_q       <= idx_d;
    end
  end

  assign bit_out  = bit_q;
  assign flag_out = flag_q;
  assign err_out  = err_q;
  assign min_out  = min_q;
  assign idx_out  = idx_q;
  assign sync_out = (state_q == LOCK);

endmodule

// File: tb/tb_pulse_decoder.sv
// Self-checking bench for pulse_decoder: timestamp-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pulse_decoder;

  localparam int FILT    = 3;
  localparam int T_MIN   = 10;
  localparam int T_SPLIT = 20;
  localparam int T_MAX   = 40;
  localparam int T_GAP   = 100;
  localparam bit LONG    = 1'b0;
  localparam int SAT     = 65535;

  logic       clk_in = 1'b0;
  logic       GSR = 1'b1;
  logic       sgn_in = 1'b0;
  logic       bit_out, flag_out, err_out, min_out, sync_out;
  logic [5:0] idx_out;

  int n_chk  = 0;
  int n_fail = 0;

  pulse_decoder #(
    .CNT_W(16), .FILT(FILT), .T_MIN(T_MIN), .T_SPLIT(T_SPLIT),
    .T_MAX(T_MAX), .T_GAP(T_GAP), .LONG_IS_ONE(LONG)
  ) dut (
    .clk_in(clk_in), .GSR(GSR), .sgn_in(sgn_in),
    .bit_out(bit_out), .flag_out(flag_out), .err_out(err_out),
    .min_out(min_out), .idx_out(idx_out), .sync_out(sync_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw history window, edge timestamps, and decode rules on pulse/gap lengths.
  bit hist [0:FILT+1];
  bit mfilt, pend_rise, pend_fall, m_valid, flip;
  int cyc, t_rise, t_low, w, gap;
  int e_idx;
  bit e_bit, e_flag, e_err, e_min, e_sync;

  always @(posedge clk_in) begin
    cyc++;
    if (GSR) begin
      for (int i = 0; i <= FILT + 1; i++) hist[i] = 1'b0;
      mfilt = 0; pend_rise = 0; pend_fall = 0;
      t_rise = cyc; t_low = cyc;
      e_idx = 0; e_bit = 0; e_flag = 0; e_err = 0; e_min = 0; e_sync = 0;
      m_valid = 1;
    end else begin
      e_flag = 0; e_err = 0; e_min = 0;
      if (pend_fall) begin
        w = cyc - 1 - t_rise;
        if (w > SAT) w = SAT;
        if (w >= T_MIN && w <= T_MAX && e_idx != 59) begin
          e_flag = 1;
          e_bit  = (w > T_SPLIT) ? LONG : !LONG;
          e_idx++;
        end else begin
          e_err  = 1;
          e_sync = 0;
        end
      end
      if (pend_rise) begin
        gap = cyc - 1 - t_low;
        if (gap > SAT) gap = SAT;
        if (gap > T_GAP) begin
          e_min = 1; e_idx = 0; e_sync = 1;
        end
      end
      pend_rise = 0; pend_fall = 0;
      for (int i = FILT + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = sgn_in;
      flip = 1;
      for (int j = 0; j < FILT; j++) if (hist[2+j] == mfilt) flip = 0;
      if (flip) begin
        mfilt = !mfilt;
        if (mfilt) begin t_rise = cyc; pend_rise = 1; end
        else begin t_low = cyc; pend_fall = 1; end
      end
    end
  end

  always @(negedge clk_in) begin
    if (m_valid) begin
      chk("model_bit",  bit_out,  e_bit);
      chk("model_flag", flag_out, e_flag);
      chk("model_err",  err_out,  e_err);
      chk("model_min",  min_out,  e_min);
      chk("model_idx",  idx_out,  e_idx);
      chk("model_sync", sync_out, e_sync);
    end
  end

  task automatic hold(input bit v, input int cycles);
    sgn_in = v;
    repeat (cycles) @(negedge clk_in);
  endtask

  task automatic do_pulse(input int lo, input int hi);
    hold(1'b0, lo);
    hold(1'b1, hi);
    sgn_in = 1'b0;
  endtask

  initial begin
    repeat (4) @(negedge clk_in);
    chk("rst_flag", flag_out, 0);
    chk("rst_idx",  idx_out,  0);
    chk("rst_sync", sync_out, 0);
    chk("rst_bit",  bit_out,  0);
    GSR = 1'b0;

    // First marker: long low gap, 15-cycle pulse
    hold(1'b0, 150);
    hold(1'b1, 6);
    chk("mark_min",  min_out,  1);
    chk("mark_sync", sync_out, 1);
    chk("mark_idx",  idx_out,  0);
    hold(1'b1, 9);
    hold(1'b0, 6);
    chk("p15_flag", flag_out, 1);
    chk("p15_bit",  bit_out,  1);
    chk("p15_idx",  idx_out,  1);

    do_pulse(50, 30); repeat (6) @(negedge clk_in);
    chk("p30_flag", flag_out, 1);
    chk("p30_bit",  bit_out,  0);
    chk("p30_min",  min_out,  0);
    chk("p30_idx",  idx_out,  2);

    do_pulse(50, 20); repeat (6) @(negedge clk_in);
    chk("p20_flag", flag_out, 1);
    chk("p20_bit",  bit_out,  1);

    do_pulse(50, 5); repeat (6) @(negedge clk_in);
    chk("p5_err",  err_out,  1);
    chk("p5_flag", flag_out, 0);
    chk("p5_sync", sync_out, 0);
    chk("p5_bit",  bit_out,  1);
    chk("p5_idx",  idx_out,  3);

    do_pulse(50, 200); repeat (6) @(negedge clk_in);
    chk("p200_err", err_out, 1);

    // Glitch splits a long gap; the gap must still count as one marker gap
    hold(1'b0, 60);
    hold(1'b1, 2);
    hold(1'b0, 60);
    hold(1'b1, 6);
    chk("glitch_min",  min_out,  1);
    chk("glitch_sync", sync_out, 1);
    hold(1'b1, 9);
    hold(1'b0, 6);
    chk("glitch_idx", idx_out, 1);

    for (int i = 2; i <= 59; i++) begin
      do_pulse(30, 15); repeat (6) @(negedge clk_in);
      chk("frame_flag", flag_out, 1);
      chk("frame_idx",  idx_out,  i);
    end
    do_pulse(30, 15); repeat (6) @(negedge clk_in);
    chk("ovr_err",  err_out,  1);
    chk("ovr_flag", flag_out, 0);
    chk("ovr_sync", sync_out, 0);
    chk("ovr_idx",  idx_out,  59);

    // Relock, advance to index 17, then reset mid-pulse
    do_pulse(150, 15); repeat (6) @(negedge clk_in);
    for (int i = 0; i < 16; i++) begin
      do_pulse(30, 15); repeat (6) @(negedge clk_in);
    end
    chk("pre_rst_idx",  idx_out,  17);
    chk("pre_rst_sync", sync_out, 1);
    hold(1'b1, 10);
    GSR = 1'b1;
    sgn_in = 1'b0;
    @(negedge clk_in);
    chk("mid_rst_idx",  idx_out,  0);
    chk("mid_rst_sync", sync_out, 0);
    chk("mid_rst_bit",  bit_out,  0);
    chk("mid_rst_err",  err_out,  0);
    repeat (2) @(negedge clk_in);
    GSR = 1'b0;
    do_pulse(20, 15); repeat (6) @(negedge clk_in);
    chk("post_rst_flag", flag_out, 1);
    chk("post_rst_idx",  idx_out,  1);
    chk("post_rst_sync", sync_out, 0);
    repeat (10) @(negedge clk_in);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_decoder.md
PULSE_DECODER -- requirements
Module: pulse_decoder

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- CNT_W, 16, width of pulse and gap counters.
- FILT, 4, glitch-filter depth in clk_in cycles (>=1).
- T_MIN, 50, shortest legal high pulse in cycles.
- T_SPLIT, 850, pulse/bit boundary in cycles.
- T_MAX, 1500, longest legal high pulse in cycles.
- T_GAP, 2500, low-gap length that signals a minute marker.
- LONG_IS_ONE, 0, bit value decoded for a long pulse.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk_in, input, 1, sole clock, rising edge.
- GSR, input, 1, reset, synchronous, active-high.
- sgn_in, input, 1, raw asynchronous pulse signal.
- bit_out, output, 1, last decoded bit, held until the next valid decode.
- flag_out, output, 1, one-cycle strobe: bit_out updated.
- err_out, output, 1, one-cycle strobe: illegal pulse or frame overrun.
- min_out, output, 1, one-cycle strobe: minute marker detected.
- idx_out, output, 6, index of the next bit within the minute (0..59).
- sync_out, output, 1, level: frame aligned since the last marker.

Function
REQ-003 sgn_in passes through a 2-flop synchroniser; the filtered level changes only after FILT consecutive synchronised samples equal the new value.
REQ-004 Latency from an sgn_in edge to a filtered edge is exactly 2+FILT cycles.
REQ-005 hcnt increments each cycle the filtered level is high, saturates at all-ones, and clears in the cycle after a falling edge.
REQ-006 lcnt behaves the same way while the filtered level is low; it clears after a rising edge.
REQ-007 Falling edge, legal pulse (T_MIN <= hcnt <= T_MAX): flag_out=1 in the next cycle; bit_out=LONG_IS_ONE if hcnt>T_SPLIT, otherwise ~LONG_IS_ONE; idx_out increments in the same cycle.
REQ-008 Falling edge, illegal pulse (hcnt<T_MIN or hcnt>T_MAX, including saturation): err_out=1, flag_out=0; bit_out and idx_out unchanged; sync_out cleared.
REQ-009 Falling edge, legal pulse while idx_out==59: treated as a frame overrun; err_out=1, flag_out=0, sync_out cleared, idx_out stays 59.
REQ-010 Rising edge with lcnt>T_GAP: min_out=1 in the next cycle; idx_out set to 0; sync_out set.
REQ-011 Rising edge with lcnt<=T_GAP: no strobe.
REQ-012 State machine:
- HUNT (sync_out=0) moves to LOCK on a marker.
- LOCK moves to HUNT on any err_out.
- A marker in LOCK keeps LOCK and restarts the index.
REQ-013 Decoding (REQ-007) runs identically in HUNT and LOCK; only sync_out differs between them.
REQ-014 flag_out, err_out and min_out are each high for exactly one cycle per event; flag_out and err_out are never high together.
REQ-015 All threshold comparisons are unsigned at CNT_W bits; a pulse exactly at T_SPLIT decodes as short.
REQ-016 Rising and falling filtered edges cannot coincide, so no priority between them is defined.
REQ-017 A glitch shorter than FILT cycles produces no edge, no counter change and no strobe.

Reset
REQ-018 GSR is sampled on the rising edge of clk_in and overrides all other activity, including mid-pulse.
REQ-019 Values while GSR is high and in the cycle after it drops:
- synchroniser, filter and filtered level all 0;
- hcnt and lcnt 0;
- bit_out, flag_out, err_out, min_out 0;
- idx_out 0, sync_out 0, state HUNT.
REQ-020 A pulse in progress when GSR is released is measured only from release; no strobe fires during reset.

Verification
Bench parameters: FILT=3, T_MIN=10, T_SPLIT=20, T_MAX=40, T_GAP=100, LONG_IS_ONE=0.
REQ-021 Low 150 cycles, then a 15-cycle high pulse -> min_out strobe at the rising edge +6 cycles, sync_out=1, idx_out=0; then flag_out=1, bit_out=1, idx_out=1.
REQ-022 A 30-cycle high pulse followed by a 50-cycle low -> flag_out=1, bit_out=0, no min_out; a pulse of exactly 20 cycles -> bit_out=1.
REQ-023 A 5-cycle pulse -> err_out=1, sync_out=0, bit_out unchanged; a 200-cycle pulse -> err_out=1.
REQ-024 A 2-cycle high glitch inside a low gap -> no strobes, and the gap still counts toward T_GAP.
REQ-025 After a marker, 60 legal pulses without a marker -> flag_out strobes for pulses 1..59, idx_out=59; the 60th pulse gives err_out=1 and sync_out=0.
REQ-026 GSR asserted mid-pulse in LOCK with idx_out=17 -> next cycle all outputs 0 and state HUNT; a 15-cycle pulse after release decodes with idx_out 0->1.
